// File: rtl/pc_next_unit.sv
// Program counter next-address unit: sequential advance, branch/jump redirect,
// stall hold with a one-entry pending redirect, and a one-cycle squash bubble.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic        pc_valid,
    output logic        redirect
);

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc_d;
    logic              pend_v, pend_v_d;
    logic [PC_W-1:0]   pend_t, pend_t_d;
    logic              pc_valid_d, redirect_d;
    logic              req_v;
    logic [PC_W-1:0]   req_t;
    logic [PC_W-1:0]   jump_target;

    // Address arithmetic wraps modulo 2^32
    assign pc_plus4      = pc + PC_W'(4);
    assign branch_target = pc_plus4 + (branch_offset << 2);
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

    // Jump outranks a taken branch
    assign req_v = jump | branch_taken;
    assign req_t = jump ? jump_target : branch_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pend_v   <= 1'b0;
            pend_t   <= '0;
            pc_valid <= 1'b0;
            redirect <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            pend_v   <= pend_v_d;
            pend_t   <= pend_t_d;
            pc_valid <= pc_valid_d;
            redirect <= redirect_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        pend_v_d = pend_v;
        pend_t_d = pend_t;

        case (state)
            BOOT: state_d = RUN;
            RUN: begin
                if (stall) begin
                    state_d = HOLD;
                    if (req_v) begin
                        pend_v_d = 1'b1;
                        pend_t_d = req_t;
                    end
                end else if (req_v) begin
                    pc_d    = req_t;
                    state_d = BUBBLE;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            HOLD: begin
                if (req_v) begin
                    pend_v_d = 1'b1;
                    pend_t_d = req_t;
                end
                // On release the newest request (this cycle, else the stored one) is applied
                if (!stall) begin
                    pend_v_d = 1'b0;
                    if (req_v) begin
                        pc_d    = req_t;
                        state_d = BUBBLE;
                    end else if (pend_v) begin
                        pc_d    = pend_t;
                        state_d = BUBBLE;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = RUN;
                    end
                end
            end
            BUBBLE: state_d = stall ? HOLD : RUN;
            default: state_d = BOOT;
        endcase

        pc_valid_d = (state_d == RUN) || (state_d == HOLD);
        redirect_d = (state_d == BUBBLE);
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomized and directed check of pc_next_unit against a cycle-level reference model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, branch_target;
    logic        pc_valid, redirect;

    logic        w_zero1  = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic [25:0] w_zero26 = 26'h0;
    logic [31:0] w_pc, w_pc_plus4, w_branch_target;
    logic        w_pc_valid, w_redirect;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic        exp_valid, exp_redir;
    bit          boot_slot, squash_slot;
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    pc_next_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
        .pc(pc), .pc_plus4(pc_plus4), .branch_target(branch_target),
        .pc_valid(pc_valid), .redirect(redirect)
    );

    pc_next_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .stall(w_zero1), .branch_taken(w_zero1),
        .branch_offset(w_zero32), .jump(w_zero1), .jump_index(w_zero26),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .branch_target(w_branch_target),
        .pc_valid(w_pc_valid), .redirect(w_redirect)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_pc      = 32'h0;
        exp_valid   = 1'b0;
        exp_redir   = 1'b0;
        boot_slot   = 1'b1;
        squash_slot = 1'b0;
        pend_q.delete();
    endtask

    // One clock of the reference: boot and squash slots ignore inputs; any valid-fetch
    // cycle either parks the newest request (stalled) or applies newest-or-parked request.
    task automatic model_step(input logic s, input logic b, input logic [31:0] o,
                              input logic j, input logic [25:0] idx);
        logic [31:0] p4, req;
        bit          have;
        p4        = exp_pc + 32'd4;
        exp_redir = 1'b0;
        if (boot_slot) begin
            boot_slot = 1'b0;
            exp_valid = 1'b1;
        end else if (squash_slot) begin
            squash_slot = 1'b0;
            exp_valid   = 1'b1;
        end else begin
            have = j || b;
            req  = j ? {p4[31:28], idx, 2'b00} : p4 + o * 32'd4;
            if (s) begin
                if (have) begin
                    pend_q.delete();
                    pend_q.push_back(req);
                end
            end else begin
                if (!have && pend_q.size() > 0) begin
                    have = 1'b1;
                    req  = pend_q[0];
                end
                pend_q.delete();
                if (have) begin
                    exp_pc      = req;
                    squash_slot = 1'b1;
                    exp_valid   = 1'b0;
                    exp_redir   = 1'b1;
                end else begin
                    exp_pc = p4;
                end
            end
        end
    endtask

    // Entered and left at a falling edge
    task automatic step(input logic s, input logic b, input logic [31:0] o,
                        input logic j, input logic [25:0] idx);
        check("pc", pc, exp_pc);
        check("pc_valid", 32'(pc_valid), 32'(exp_valid));
        check("redirect", 32'(redirect), 32'(exp_redir));
        stall = s; branch_taken = b; branch_offset = o; jump = j; jump_index = idx;
        #1;
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("branch_target", branch_target, exp_pc + 32'd4 + o * 32'd4);
        @(posedge clk);
        model_step(s, b, o, j, idx);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    // Asynchronous reset pulse landing between clock edges
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(pc_valid), 32'h0);
        check("rst_redirect", 32'(redirect), 32'h0);
        model_reset();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 32'h0; jump_index = 26'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset release and sequential advance, plus wrap instance
        check("boot_pc", pc, 32'h0);
        check("boot_valid", 32'(pc_valid), 32'h0);
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        idle(1);
        check("run_pc0", pc, 32'h0);
        check("run_valid", 32'(pc_valid), 32'h1);
        check("wrap_pc1", w_pc, 32'hFFFF_FFF8);
        idle(1);
        check("seq_pc4", pc, 32'h4);
        check("wrap_pc2", w_pc, 32'hFFFF_FFFC);
        idle(1);
        check("seq_pc8", pc, 32'h8);
        check("wrap_pc3", w_pc, 32'h0000_0000);

        // Backward branch from 0x100
        step(1'b0, 1'b0, 32'h0, 1'b1, 26'h40);
        idle(1);
        check("at_100", pc, 32'h100);
        branch_offset = 32'hFFFF_FFFE;
        #1 check("bt_fc", branch_target, 32'hFC);
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
        check("br_pc", pc, 32'hFC);
        check("br_redirect", 32'(redirect), 32'h1);
        check("br_bubble", 32'(pc_valid), 32'h0);
        idle(1);
        check("br_fetch", pc, 32'hFC);
        check("br_fetch_valid", 32'(pc_valid), 32'h1);
        check("br_redirect_off", 32'(redirect), 32'h0);

        // Jump outranks branch
        step(1'b0, 1'b1, 32'h03FF_FFD0, 1'b0, 26'h0);
        idle(1);
        check("at_10000040", pc, 32'h1000_0040);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 26'h10);
        check("jmp_pc", pc, 32'h1000_0040);
        check("jmp_redirect", 32'(redirect), 32'h1);

        // Branch parked during a three-cycle stall
        idle(1);
        step(1'b0, 1'b1, 32'h3C00_006F, 1'b0, 26'h0);
        idle(1);
        check("at_200", pc, 32'h200);
        step(1'b1, 1'b1, 32'h4, 1'b0, 26'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        check("hold_pc", pc, 32'h200);
        check("hold_valid", 32'(pc_valid), 32'h1);
        idle(1);
        check("pend_pc", pc, 32'h214);
        check("pend_redirect", 32'(redirect), 32'h1);
        check("pend_bubble", 32'(pc_valid), 32'h0);
        idle(1);
        check("pend_fetch_valid", 32'(pc_valid), 32'h1);

        // Async reset during HOLD with a parked redirect
        step(1'b1, 1'b1, 32'h8, 1'b0, 26'h0);
        async_reset();
        idle(4);
        check("post_rst_pc", pc, 32'hC);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic s, b, j;
            logic [31:0] o;
            s = ($urandom_range(99) < 30);
            b = ($urandom_range(99) < 20);
            j = ($urandom_range(99) < 10);
            o = ($urandom_range(3) == 0) ? $urandom : 32'($signed(8'($urandom)));
            if ($urandom_range(99) < 2) async_reset();
            else step(s, b, o, j, 26'($urandom));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold PC; no sequential advance.
REQ-005 branch_taken  input  1  branch resolved taken this cycle.
REQ-006 branch_offset  input  32  sign-extended word offset (imm16 sign-extended by caller).
REQ-007 jump  input  1  J-type redirect this cycle.
REQ-008 jump_index  input  26  J-type instruction index field.
REQ-009 pc  output  32  current fetch address (registered).
REQ-010 pc_plus4  output  32  combinational pc + 4; feeds the sequential input of the downstream 32-bit 2:1 PC mux.
REQ-011 branch_target  output  32  combinational pc_plus4 + (branch_offset << 2); feeds the redirect input of the downstream 2:1 PC mux.
REQ-012 pc_valid  output  1  registered; pc holds a fetchable address this cycle.
REQ-013 redirect  output  1  registered; pulses 1 cycle when PC was loaded from a branch/jump target.

Function
REQ-014 All arithmetic shall be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; no overflow flag.
REQ-015 Jump target shall be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-016 FSM states shall be BOOT, RUN, HOLD, BUBBLE.
REQ-017 BOOT: entered on reset; pc_valid=0; next cycle -> RUN with pc unchanged (RESET_PC).
REQ-018 RUN: pc_valid=1; next-PC priority jump > branch_taken > sequential (pc_plus4).
REQ-019 RUN with stall=1: pc held; -> HOLD; any jump/branch_taken in that cycle shall be latched into a one-entry pending-redirect register (target + valid) instead of applied.
REQ-020 HOLD: pc held, pc_valid=1; new jump/branch_taken while in HOLD shall overwrite the pending entry (latest wins); on stall=0, pc loads pending target if pending valid (-> BUBBLE) else pc_plus4 (-> RUN); pending valid clears.
REQ-021 RUN with jump or branch_taken and stall=0: pc loads target, redirect=1 next cycle, -> BUBBLE.
REQ-022 BUBBLE: exactly one cycle with pc_valid=0 (squash slot); pc held; redirect/branch/jump inputs ignored; -> RUN, or -> HOLD if stall=1 (pc still held).
REQ-023 redirect shall be 1 only in the first cycle of BUBBLE; 0 otherwise.
REQ-024 Latency: sequential advance 1 cycle; redirect to first valid fetch of target 2 cycles.
REQ-025 Branch/jump inputs in BOOT shall be ignored.

Reset
REQ-026 reset=1 shall asynchronously force pc=RESET_PC, pc_valid=0, redirect=0, pending valid=0, state=BOOT, regardless of clk.
REQ-027 Reset asserted mid-HOLD or mid-BUBBLE shall discard any pending redirect.
REQ-028 After reset deassertion, first cycle pc_valid=1 shall be the second rising edge.

Verification
REQ-029 Reset release, no stall, 4 cycles -> pc = 0x0, 0x0 (valid), 0x4, 0x8; pc_valid 0,1,1,1.
REQ-030 pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFFE -> branch_target=0xFC; next cycle pc=0xFC, redirect=1, pc_valid=0; following cycle pc_valid=1, pc=0xFC.
REQ-031 pc=0x1000_0040, jump=1 with branch_taken=1, jump_index=0x000_0010 -> pc=0x1000_0040 (jump wins over branch), redirect=1.
REQ-032 pc=0x200, stall=1 and branch_taken=1 (offset 4) same cycle, stall held 3 cycles -> pc stays 0x200; stall drops -> pc=0x214, one BUBBLE cycle.
REQ-033 RESET_PC=0xFFFF_FFF8, run 3 cycles -> pc=0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
REQ-034 Assert reset asynchronously between edges during HOLD with pending redirect -> pc=RESET_PC immediately; after release no redirect pulse occurs.
